serial_word_collector: RTL and testbench
========================================

// Module: serial_word_collector
// PURPOSE
// - Downstream stage of the bit-serial two's-complement unit. Collects its registered serial
//   output (LSB first) into parallel WIDTH-bit words.
// - Presents each completed word on a valid/ready handshake to the parallel consumer.
// - Frame alignment comes from a start strobe, delayed upstream so it lines up with bit 0.
// - Flags frame restarts and bits dropped under backpressure.
// PARAMETERS
// - WIDTH  default 8  word length in bits; legal range 2..32.
// PORTS
// - clk        in   1      single clock, all state updates on its rising edge
// - rst_n      in   1      synchronous, active-low reset (sampled on rising clk edge)
// - bit_in     in   1      serial data bit, LSB of word first
// - in_valid   in   1      bit_in is valid this cycle
// - in_start   in   1      qualifies bit_in as bit 0 of a new word; ignored unless in_valid=1
// - in_ready   out  1      comb.: 0 only when state=FULL and out_ready=0
// - data_out   out  WIDTH  assembled word, stable while out_valid=1
// - out_valid  out  1      data_out holds a complete word
// - out_ready  in   1      consumer accepts word when out_valid & out_ready
// - frame_err  out  1      one-cycle pulse: in_start arrived while a partial word was in progress
// - overflow   out  1      sticky: a valid bit was dropped in FULL; cleared only by reset
// BEHAVIOUR
// - Reset (rst_n=0 at clk edge), applies in any state, including mid-word:
//   - state=IDLE, bit count=0, shift register=0, data_out=0.
//   - out_valid=0, frame_err=0, overflow=0.
//   - Partial word is discarded.
// - Shift rule: sreg <= {bit_in, sreg[WIDTH-1:1]}, so after WIDTH shifts the first bit sits in bit 0.
// - Bit counter is $clog2(WIDTH+1) bits wide; it never exceeds WIDTH-1 outside FULL.
// - IDLE:
//   - in_valid & in_start: shift bit in, cnt=1, go to COLLECT.
//   - in_valid & !in_start: bit ignored; no flag raised.
// - COLLECT:
//   - in_valid & !in_start: shift, cnt++.
//   - If that shift is the WIDTH-th bit: latch the word into data_out, out_valid<=1, go to FULL.
//   - in_valid & in_start: discard the partial word, load the bit as bit 0, cnt=1, frame_err=1 for one cycle.
//   - in_valid=0: hold; no timeout.
// - FULL: out_valid=1 and data_out is frozen until the handshake completes.
//   - out_ready=1 with no new start bit:
//     - out_valid<=0, go to IDLE.
//     - A same-cycle bit without in_start is ignored, as in IDLE.
//   - out_ready=1 & in_valid & in_start: zero-bubble handoff.
//     - Word accepted; the new bit is shifted into a cleared register; cnt=1; go to COLLECT.
//   - out_ready=0 & in_valid: bit dropped, overflow<=1, data_out unchanged.
// - Latency: last bit sampled at edge N -> out_valid=1 and data_out valid after edge N (cycle N+1).
// - Peak throughput: one word per WIDTH cycles with continuous bits and out_ready=1; no idle cycle needed.
// - Simultaneous in_start and last-bit count: in_start wins; the word restarts (frame_err pulses).
// - All outputs are registered except in_ready.
// TESTING
// 1. WIDTH=8: reset, then bits 0,1,0,1,1,0,1,0 with start on the 1st bit, out_ready=1
//    -> out_valid one cycle after the 8th bit, data_out=8'h5A.
// 2. Backpressure: word 8'hC3 completes with out_ready=0 for 5 cycles, and in_valid=1 on cycle 2
//    -> data_out held at 8'hC3, in_ready=0, overflow=1 (sticky).
//    -> Raising out_ready accepts the word; overflow stays 1.
// 3. Restart: 4 bits of 8'hFF, then in_start + 8 bits of 8'h81
//    -> frame_err pulses exactly one cycle, output word=8'h81.
// 4. Back-to-back: 8'h01 then 8'hFE contiguous, next start coinciding with the handshake,
//    out_ready=1 -> two out_valid pulses 8 cycles apart, values 8'h01 and 8'hFE.
// 5. Reset mid-word: rst_n=0 after 3 bits, then a clean frame of 8'h3C
//    -> all outputs 0 during reset; output word=8'h3C; frame_err never asserted.
// 6. Chained with the two's-complement stage in complement mode: input word 8'h14 serialised
//    -> collected word=8'hEC.

Source files
------------

// File: rtl/serial_word_collector.sv
// Collects a registered LSB-first serial bit stream into WIDTH-bit words
// and hands each word to a parallel consumer over a valid/ready handshake.
module serial_word_collector #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             bit_in,
    input  logic             in_valid,
    input  logic             in_start,
    output logic             in_ready,
    output logic [WIDTH-1:0] data_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             frame_err,
    output logic             overflow
);

    // state     | meaning
    // S_IDLE    | waiting for a start-qualified bit 0
    // S_COLLECT | partial word in progress, r_cnt bits received
    // S_FULL    | complete word on data_out, waiting for the handshake

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_FULL    = 2'd2
    } state_t;

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_sreg;
    logic [WIDTH-1:0] r_data;
    logic             r_out_valid;
    logic             r_frame_err;
    logic             r_overflow;

    logic [WIDTH-1:0] w_shift;
    logic [WIDTH-1:0] w_load;
    logic             w_start_bit;
    logic             w_data_bit;

    assign w_shift     = {bit_in, r_sreg[WIDTH-1:1]};
    // A new word starts from a cleared register so no stale bits survive.
    assign w_load      = {bit_in, {(WIDTH-1){1'b0}}};
    assign w_start_bit = in_valid & in_start;
    assign w_data_bit  = in_valid & ~in_start;

    assign in_ready  = ~((r_state == S_FULL) & ~out_ready);
    assign data_out  = r_data;
    assign out_valid = r_out_valid;
    assign frame_err = r_frame_err;
    assign overflow  = r_overflow;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_sreg      <= '0;
            r_data      <= '0;
            r_out_valid <= 1'b0;
            r_frame_err <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_start_bit) begin
                        r_sreg  <= w_load;
                        r_cnt   <= CNT_ONE;
                        r_state <= S_COLLECT;
                    end
                end
                S_COLLECT: begin
                    if (w_start_bit) begin
                        r_sreg      <= w_load;
                        r_cnt       <= CNT_ONE;
                        r_frame_err <= 1'b1;
                    end else if (w_data_bit) begin
                        r_sreg <= w_shift;
                        if (r_cnt == CNT_LAST) begin
                            r_data      <= w_shift;
                            r_out_valid <= 1'b1;
                            r_cnt       <= CNT_FULL;
                            r_state     <= S_FULL;
                        end else begin
                            r_cnt <= r_cnt + CNT_ONE;
                        end
                    end
                end
                S_FULL: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        if (w_start_bit) begin
                            r_sreg  <= w_load;
                            r_cnt   <= CNT_ONE;
                            r_state <= S_COLLECT;
                        end else begin
                            r_cnt   <= '0;
                            r_state <= S_IDLE;
                        end
                    end else if (in_valid) begin
                        r_overflow <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_cnt       <= '0;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_word_collector.sv
// Directed self-checking bench for serial_word_collector at WIDTH=8.
`timescale 1ns/1ps
module tb_serial_word_collector;

    logic       clk;
    logic       rst_n;
    logic       bit_in;
    logic       in_valid;
    logic       in_start;
    logic       in_ready;
    logic [7:0] data_out;
    logic       out_valid;
    logic       out_ready;
    logic       frame_err;
    logic       overflow;

    int checks = 0;
    int errors = 0;

    serial_word_collector #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bit_in    (bit_in),
        .in_valid  (in_valid),
        .in_start  (in_start),
        .in_ready  (in_ready),
        .data_out  (data_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .frame_err (frame_err),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic v, input logic s, input logic b);
        in_valid = v;
        in_start = s;
        bit_in   = b;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; out_ready = 1'b1; drive(1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        checks++;
        if ({out_valid, frame_err, overflow} !== 3'b000 || data_out !== 8'h00 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset: ov=%b fe=%b of=%b data=%h ir=%b, want 0 0 0 00 1",
                     out_valid, frame_err, overflow, data_out, in_ready);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_idle_ignore();
        logic seen = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k > 0 && (out_valid || frame_err)) seen = 1'b1;
            drive(1'b1, 1'b0, 1'(k % 2));
        end
        @(negedge clk);
        if (out_valid || frame_err) seen = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL idle_ignore: out_valid/frame_err seen=%b, want 0", seen);
        end
    endtask

    task automatic test_basic();
        logic [7:0] w = 8'h5A;
        logic early = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid) early = 1'b1;
            drive(1'b1, i == 0, w[i]);
        end
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0);
        checks++;
        if (early !== 1'b0) begin
            errors++;
            $display("FAIL basic_latency: out_valid before last bit=%b, want 0", early);
        end
        checks++;
        if (out_valid !== 1'b1 || data_out !== 8'h5A) begin
            errors++;
            $display("FAIL basic_word: out_valid=%b data=%h, want 1 5a", out_valid, data_out);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_accept: out_valid=%b, want 0", out_valid);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] w = 8'hC3;
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            drive(1'b1, i == 0, w[i]);
        end
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || data_out !== 8'hC3 || in_ready !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL bp_full: ov=%b data=%h ir=%b of=%b, want 1 c3 0 0",
                     out_valid, data_out, in_ready, overflow);
        end
        for (int c = 1; c < 5; c++) begin
            @(negedge clk);
            drive(c == 2, 1'b0, 1'b0);
        end
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || data_out !== 8'hC3 || in_ready !== 1'b0 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL bp_drop: ov=%b data=%h ir=%b of=%b, want 1 c3 0 1",
                     out_valid, data_out, in_ready, overflow);
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_in_ready: in_ready=%b with out_ready=1, want 1", in_ready);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL bp_accept: ov=%b of=%b, want 0 1", out_valid, overflow);
        end
    endtask

    task automatic test_restart();
        logic [7:0] w = 8'h81;
        int pulses = 0;
        logic pulse_at_start = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (frame_err) pulses++;
            drive(1'b1, i == 0, 1'b1);
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (frame_err) pulses++;
            if (i == 1) pulse_at_start = frame_err;
            drive(1'b1, i == 0, w[i]);
        end
        @(negedge clk);
        if (frame_err) pulses++;
        drive(1'b0, 1'b0, 1'b0);
        checks++;
        if (pulses !== 1 || pulse_at_start !== 1'b1) begin
            errors++;
            $display("FAIL restart_frame_err: pulses=%0d at_start=%b, want 1 1", pulses, pulse_at_start);
        end
        checks++;
        if (out_valid !== 1'b1 || data_out !== 8'h81) begin
            errors++;
            $display("FAIL restart_word: ov=%b data=%h, want 1 81", out_valid, data_out);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [15:0] stream = {8'hFE, 8'h01};
        int n_valid = 0;
        int pos[2];
        logic [7:0] got[2];
        logic ir_low = 1'b0;
        out_ready = 1'b1;
        pos[0] = -1; pos[1] = -1; got[0] = 8'h00; got[1] = 8'h00;
        for (int k = 0; k < 18; k++) begin
            @(negedge clk);
            if (out_valid) begin
                if (n_valid < 2) begin
                    pos[n_valid] = k;
                    got[n_valid] = data_out;
                end
                n_valid++;
            end
            if (!in_ready) ir_low = 1'b1;
            if (k < 16) drive(1'b1, (k % 8) == 0, stream[k]);
            else drive(1'b0, 1'b0, 1'b0);
        end
        checks++;
        if (n_valid !== 2 || pos[0] !== 8 || pos[1] !== 16) begin
            errors++;
            $display("FAIL b2b_timing: pulses=%0d at %0d,%0d, want 2 at 8,16", n_valid, pos[0], pos[1]);
        end
        checks++;
        if (got[0] !== 8'h01 || got[1] !== 8'hFE) begin
            errors++;
            $display("FAIL b2b_data: words %h,%h, want 01,fe", got[0], got[1]);
        end
        checks++;
        if (ir_low !== 1'b0 || frame_err !== 1'b0) begin
            errors++;
            $display("FAIL b2b_flow: in_ready_low=%b frame_err=%b, want 0 0", ir_low, frame_err);
        end
    endtask

    task automatic test_reset_midword();
        logic [7:0] w = 8'h3C;
        logic fe_seen = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(1'b1, i == 0, 1'b1);
        end
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({out_valid, frame_err, overflow} !== 3'b000 || data_out !== 8'h00) begin
            errors++;
            $display("FAIL midword_reset: ov=%b fe=%b of=%b data=%h, want 0 0 0 00",
                     out_valid, frame_err, overflow, data_out);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (frame_err) fe_seen = 1'b1;
            drive(1'b1, i == 0, w[i]);
        end
        @(negedge clk);
        if (frame_err) fe_seen = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || data_out !== 8'h3C || fe_seen !== 1'b0) begin
            errors++;
            $display("FAIL midword_word: ov=%b data=%h fe_seen=%b, want 1 3c 0",
                     out_valid, data_out, fe_seen);
        end
        @(negedge clk);
    endtask

    task automatic test_twos_complement_chain();
        logic [7:0] src = 8'h14;
        logic [7:0] w;
        w = ~src + 8'd1;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            drive(1'b1, i == 0, w[i]);
        end
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || data_out !== 8'hEC) begin
            errors++;
            $display("FAIL twos_chain: ov=%b data=%h, want 1 ec", out_valid, data_out);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_idle_ignore();
        test_basic();
        test_backpressure();
        test_restart();
        test_back_to_back();
        test_reset_midword();
        test_twos_complement_chain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
